rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one datapath resource (shared bus / register-file write port) among 8 requesters.
- The selected requester index is registered and decoded into a one-hot grant vector, 3-to-8 decoder style; the grant is gated by an enable input.
- A hold-limit counter forces release so no requester can starve the others.
- Sits between the requesting units and the shared resource; the resource mux selects with gnt_idx, and requesters watch their own gnt bit.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant may stay asserted (legal range 2..255).
- CNT_W, 8, width of the hold counter (must satisfy 2^CNT_W > MAX_HOLD).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; gates new grants only.
- req  input  8  request vector; req[i] high = requester i wants, or is still using, the resource.
- gnt  output  8  one-hot grant; all zero when idle; registered.
- gnt_idx  output  3  binary index of the granted requester; holds its last value when idle; registered.
- gnt_valid  output  1  high while any grant is active (equals OR of gnt).
- timeout  output  1  one-cycle pulse when a grant was removed by the hold limit.

Behaviour:
Reset (rst high at clock edge):
- state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
- ptr=3'd0, hold_cnt=0.
- Reset overrides everything, including an active grant; gnt drops in the cycle after the reset edge.

Internal state:
- ptr: 3-bit round-robin pointer to the highest-priority index.
- hold_cnt: CNT_W-bit counter.
- FSM states: IDLE, BUSY.

IDLE:
- If en=1 and req!=0, select the first i with req[i]=1, scanning ptr, ptr+1, ... ptr+7, modulo 8.
- At that edge: gnt_idx<=i, gnt<=one-hot(i), gnt_valid<=1, hold_cnt<=0, state<=BUSY.
- Latency: 1 cycle from a sampled request to the grant.
- Otherwise stay in IDLE with outputs at zero.

BUSY (idx = gnt_idx):
- Release by requester: if req[idx]==0 at an edge:
  - gnt<=0, gnt_valid<=0, ptr<=idx+1 (mod 8 wrap, 7 to 0), state<=IDLE, timeout<=0.
- Release by hold limit: else if hold_cnt==MAX_HOLD-1:
  - Same release actions, but timeout<=1.
  - Net effect: gnt is high for exactly MAX_HOLD cycles.
- Otherwise: hold_cnt<=hold_cnt+1 and the grant holds.
- If both release conditions occur in the same cycle, treat it as a requester release (timeout=0).
- Changes on other req bits during BUSY are ignored, i.e. no preemption.
- en=0 during BUSY does not revoke the current grant.

General rules:
- timeout is high only in the single cycle after a limit release; otherwise 0.
- Every release is followed by at least one IDLE cycle (dead cycle), so grants are never back-to-back.
- A requester that timed out and keeps req high moves to lowest priority. If it is the only requester, it is re-granted after the dead cycle.
- gnt is always one-hot or zero. gnt_valid==|gnt at every cycle.

Test Plan:
1. Reset/idle: rst=1 for 2 cycles with req=8'hFF, then req=8'h00, en=1 -> gnt=8'h00, gnt_valid=0, timeout=0, gnt_idx=0 throughout.
2. Single request: req=8'h20 from cycle 0 to cycle 4, then 0 -> gnt=8'h20, gnt_idx=5 from cycle 1 to cycle 5; gnt=0 at cycle 6; ptr now 6.
3. Round-robin fairness: req=8'h81 held, each grant released by dropping that bit for 1 cycle, then raising it again -> grant order idx0, idx7, idx0, idx7. Then test pointer wrap: after idx7 is granted and released, ptr=0.
4. Hold limit: req=8'h08 held constantly, MAX_HOLD=16 -> gnt=8'h08 for exactly 16 cycles, timeout pulse 1 cycle as gnt drops, 1 dead cycle, then re-grant idx3.
5. Enable gating: en=0 with req=8'h44 -> no grant. Raise en -> gnt=8'h04 next cycle. Drop en mid-grant -> grant persists until req[2] falls.
6. Reset mid-grant: gnt=8'h10 active at hold_cnt=5, assert rst for 1 cycle -> gnt=0 next cycle, ptr=0. With req=8'h11 after reset, idx0 is granted first.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8
//   Round-robin arbiter sharing one datapath resource among 8 requesters.
//   A requester keeps its req bit high for as long as it uses the resource.
//   The grant is released when that bit falls, or forcibly after MAX_HOLD
//   cycles so that a greedy requester cannot starve the others. Every
//   release is followed by at least one idle cycle before the next grant.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   en         arbitration enable; only gates new grants
//   req[7:0]   request vector, one bit per requester
//   gnt[7:0]   registered one-hot grant, zero when idle
//   gnt_idx    registered binary index of the granted requester,
//              keeps its last value while idle
//   gnt_valid  high while any grant is active (OR of gnt)
//   timeout    one-cycle pulse after a grant was removed by the hold limit

module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Value of hold_cnt during the last permitted cycle of a grant.
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_next;
  logic [2:0]       ptr, ptr_next;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
  logic [2:0]       idx_next;
  logic [7:0]       gnt_next;
  logic             timeout_next;

  logic [2:0]       cand;
  logic [2:0]       sel_idx;
  logic             sel_found;

  // State register: all architectural state, cleared by the synchronous
  // reset regardless of whether a grant is currently active.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      hold_cnt <= '0;
      gnt_idx  <= 3'd0;
      gnt      <= 8'h00;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      hold_cnt <= hold_cnt_next;
      gnt_idx  <= idx_next;
      gnt      <= gnt_next;
      timeout  <= timeout_next;
    end
  end

  // Round-robin pick: the first requester found scanning ptr, ptr+1, ...
  // with 3-bit wraparound. The scan runs from the farthest offset down to
  // the nearest so that the last match written is the highest priority.
  always_comb begin
    cand      = ptr;
    sel_idx   = ptr;
    sel_found = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + 3'(k);
      if (req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state logic. In BUSY a falling req of the owner takes precedence
  // over the hold limit, so a coincident release never reports a timeout.
  // Other req bits and en are ignored while BUSY: no preemption, no revoke.
  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    hold_cnt_next = hold_cnt;
    idx_next      = gnt_idx;
    gnt_next      = gnt;
    timeout_next  = 1'b0;
    case (state)
      IDLE: begin
        gnt_next = 8'h00;
        if (en && sel_found) begin
          state_next    = BUSY;
          idx_next      = sel_idx;
          gnt_next      = 8'h01 << sel_idx;
          hold_cnt_next = '0;
        end
      end
      BUSY: begin
        if (!req[gnt_idx]) begin
          state_next = IDLE;
          gnt_next   = 8'h00;
          ptr_next   = gnt_idx + 3'd1;
        end else if (hold_cnt == HoldLast) begin
          state_next   = IDLE;
          gnt_next     = 8'h00;
          ptr_next     = gnt_idx + 3'd1;
          timeout_next = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 8'h00;
      end
    endcase
  end

  // Output logic: the valid flag follows the registered grant vector.
  always_comb begin
    gnt_valid = |gnt;
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8
//   Directed bench for rr_arbiter_8 with hand-computed expectations.
//   Inputs change 1 ns after a rising edge; outputs are sampled at the
//   same point, so each check sees the result of the edge just taken.

module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int compared;
  int mismatched;

  rr_arbiter_8 #(.MAX_HOLD(16), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for two cycles with all requests high; nothing may be granted
  // during or after reset while req is zero.
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        rst = 1'b0; req = 8'h00;
      end
      step();
      compared++;
      if (gnt !== 8'h00) begin
        mismatched++;
        $display("[TB] FAIL reset_gnt cyc=%0d got=%h want=00", k, gnt);
      end
      compared++;
      if (gnt_idx !== 3'd0) begin
        mismatched++;
        $display("[TB] FAIL reset_idx cyc=%0d got=%0d want=0", k, gnt_idx);
      end
      compared++;
      if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_flags cyc=%0d got valid=%b to=%b want 0/0", k, gnt_valid, timeout);
      end
    end
  endtask

  // Single requester 5 for five cycles, then release; afterwards the
  // pointer sits at 6, which makes idx6 beat idx0 in req=8'h41.
  task automatic test_single();
    req = 8'h20;
    for (int k = 1; k <= 5; k++) begin
      step();
      compared++;
      if (gnt !== 8'h20 || gnt_idx !== 3'd5 || gnt_valid !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL single_hold cyc=%0d got gnt=%h idx=%0d v=%b want 20/5/1", k, gnt, gnt_idx, gnt_valid);
      end
    end
    req = 8'h00;
    step();
    compared++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0 || gnt_idx !== 3'd5) begin
      mismatched++;
      $display("[TB] FAIL single_release got gnt=%h v=%b to=%b idx=%0d want 00/0/0/5", gnt, gnt_valid, timeout, gnt_idx);
    end
    req = 8'h41;
    step();
    compared++;
    if (gnt !== 8'h40 || gnt_idx !== 3'd6) begin
      mismatched++;
      $display("[TB] FAIL single_ptr6 got gnt=%h idx=%0d want 40/6", gnt, gnt_idx);
    end
    req = 8'h00;
    step();
    compared++;
    if (gnt !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL single_ptr6_release got=%h want=00", gnt);
    end
  endtask

  // Two contenders 0 and 7 alternate; the last release of idx7 wraps the
  // pointer to 0 so idx0 wins the following round.
  task automatic test_round_robin();
    logic [2:0] exp_idx;
    logic [7:0] exp_gnt;
    rst = 1'b1; req = 8'h00;
    step();
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      exp_idx = (r % 2 == 0) ? 3'd0 : 3'd7;
      exp_gnt = (r % 2 == 0) ? 8'h01 : 8'h80;
      req = 8'h81;
      step();
      compared++;
      if (gnt !== exp_gnt || gnt_idx !== exp_idx) begin
        mismatched++;
        $display("[TB] FAIL rr_grant round=%0d got gnt=%h idx=%0d want %h/%0d", r, gnt, gnt_idx, exp_gnt, exp_idx);
      end
      req = 8'h81 & ~exp_gnt;
      step();
      compared++;
      if (gnt !== 8'h00 || timeout !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL rr_release round=%0d got gnt=%h to=%b want 00/0", r, gnt, timeout);
      end
    end
    req = 8'h81;
    step();
    compared++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL rr_wrap got gnt=%h idx=%0d want 01/0", gnt, gnt_idx);
    end
    req = 8'h00;
    step();
  endtask

  // Constant request on 3: grant lasts exactly 16 cycles, timeout pulses
  // with the drop, one dead cycle, then re-grant. The second grant is
  // released by the requester in the same cycle the limit is reached,
  // which must not report a timeout.
  task automatic test_hold_limit();
    req = 8'h08;
    for (int k = 1; k <= 16; k++) begin
      step();
      compared++;
      if (gnt !== 8'h08 || timeout !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL hold_active cyc=%0d got gnt=%h to=%b want 08/0", k, gnt, timeout);
      end
    end
    step();
    compared++;
    if (gnt !== 8'h00 || timeout !== 1'b1 || gnt_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL hold_timeout got gnt=%h to=%b v=%b want 00/1/0", gnt, timeout, gnt_valid);
    end
    step();
    compared++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3 || timeout !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL hold_regrant got gnt=%h idx=%0d to=%b want 08/3/0", gnt, gnt_idx, timeout);
    end
    for (int k = 2; k <= 16; k++) begin
      step();
      compared++;
      if (gnt !== 8'h08) begin
        mismatched++;
        $display("[TB] FAIL hold_second cyc=%0d got=%h want=08", k, gnt);
      end
    end
    req = 8'h00;
    step();
    compared++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL hold_coincident got gnt=%h to=%b want 00/0", gnt, timeout);
    end
  endtask

  // en blocks new grants but never revokes an active one.
  task automatic test_enable();
    rst = 1'b1; en = 1'b1; req = 8'h00;
    step();
    rst = 1'b0; en = 1'b0; req = 8'h44;
    for (int k = 0; k < 3; k++) begin
      step();
      compared++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL en_blocked cyc=%0d got gnt=%h v=%b want 00/0", k, gnt, gnt_valid);
      end
    end
    en = 1'b1;
    step();
    compared++;
    if (gnt !== 8'h04 || gnt_idx !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL en_grant got gnt=%h idx=%0d want 04/2", gnt, gnt_idx);
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      compared++;
      if (gnt !== 8'h04) begin
        mismatched++;
        $display("[TB] FAIL en_persist cyc=%0d got=%h want=04", k, gnt);
      end
    end
    req = 8'h40;
    step();
    compared++;
    if (gnt !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL en_release got=%h want=00", gnt);
    end
    step();
    compared++;
    if (gnt !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL en_idle_block got=%h want=00", gnt);
    end
    en = 1'b1; req = 8'h00;
    step();
  endtask

  // Reset during an active grant clears it and returns the pointer to 0;
  // the pre-reset pointer (3) would have picked idx4 from req=8'h11.
  task automatic test_reset_mid_grant();
    req = 8'h10;
    step();
    compared++;
    if (gnt !== 8'h10 || gnt_idx !== 3'd4) begin
      mismatched++;
      $display("[TB] FAIL midrst_grant got gnt=%h idx=%0d want 10/4", gnt, gnt_idx);
    end
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    step();
    compared++;
    if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midrst_clear got gnt=%h idx=%0d v=%b to=%b want 00/0/0/0", gnt, gnt_idx, gnt_valid, timeout);
    end
    rst = 1'b0; req = 8'h11;
    step();
    compared++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL midrst_ptr0 got gnt=%h idx=%0d want 01/0", gnt, gnt_idx);
    end
    req = 8'h00;
    step();
    compared++;
    if (gnt !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL midrst_release got=%h want=00", gnt);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    en  = 1'b1;
    req = 8'hFF;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_limit();
    test_enable();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
